// File: rtl/hs4_sink.sv
// Clocked receiver for the asynchronous four-phase pipeline: acknowledges req_in/data_in
// with a return-to-zero handshake and buffers words in a FIFO behind a valid/ready port.
// Optional protocol checker: define HS4_SINK_PROTO_CHECK_EN to enable proto_err.
module hs4_sink #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_in,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       ack_out,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       proto_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    WAIT_REQ = 1'b0,
    ACK      = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic [DATA_W-1:0]      mem [DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic                   full, empty, push, pop;

  assign req_s = sync_q[SYNC_STAGES-1];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign empty = (wr_ptr == rd_ptr);
  assign pop   = !empty && m_ready;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      WAIT_REQ: begin
        if (req_s && !full) begin
          push    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) state_d = WAIT_REQ;
      end
      default: state_d = WAIT_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= WAIT_REQ;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], req_in};
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // data_in is bundled with req_in, so it is stable by the time req_s is seen.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  assign ack_out = (state_q == ACK);
  assign m_valid = !empty;
  assign m_data  = mem[rd_ptr[AW-1:0]];
  assign count   = wr_ptr - rd_ptr;

`ifdef HS4_SINK_PROTO_CHECK_EN
  logic req_s_prev, misuse_q, err_q;

  // A falling req_s seen in WAIT_REQ means the request was withdrawn unacknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_s_prev <= 1'b0;
      misuse_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      req_s_prev <= req_s;
      misuse_q   <= m_ready && empty;
      if ((state_q == WAIT_REQ && req_s_prev && !req_s) ||
          (misuse_q && m_ready && empty))
        err_q <= 1'b1;
    end
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_hs4_sink.sv
// Bench for hs4_sink: a queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed expectations and a randomized handshake/drain phase.
module tb_hs4_sink;
  localparam int DATA_W      = 8;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CW          = $clog2(DEPTH) + 1;
`ifdef HS4_SINK_PROTO_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req_in;
  logic [DATA_W-1:0] data_in;
  logic              ack_out;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [CW-1:0]     count;
  logic              proto_err;

  hs4_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in), .ack_out(ack_out),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] rx_q[$];
  bit                hist[$];
  bit                exp_ack, exp_err, rs_prev, misuse_prev;
  bit                rand_ready = 1'b0;
  int                max_count  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: req_s is req_in delayed SYNC_STAGES edges; the FIFO is a plain queue.
  task automatic model_loop();
    bit rs, vld, pop, push;
    logic r, rq, mr;
    logic [DATA_W-1:0] d;
    forever begin
      @(posedge clk);
      r = rst; rq = req_in; d = data_in; mr = m_ready;
      if (r) begin
        exp_q.delete();
        hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(1'b0);
        exp_ack = 0; exp_err = 0; rs_prev = 0; misuse_prev = 0;
      end else begin
        rs = hist.pop_front();
        hist.push_back(rq);
        vld  = (exp_q.size() > 0);
        pop  = vld && mr;
        push = 1'b0;
        if (!exp_ack && rs_prev && !rs) exp_err = 1;
        if (misuse_prev && mr && !vld) exp_err = 1;
        misuse_prev = mr && !vld;
        rs_prev = rs;
        if (!exp_ack) begin
          if (rs && exp_q.size() < DEPTH) begin
            push = 1'b1;
            exp_ack = 1;
          end
        end else if (!rs) begin
          exp_ack = 0;
        end
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back(d);
      end
      #1;
      check("m_ack", ack_out, exp_ack);
      check("m_valid", m_valid, exp_q.size() > 0);
      check("m_count", 32'(count), exp_q.size());
      if (exp_q.size() > 0) check("m_data", m_data, exp_q[0]);
      check("m_proto_err", proto_err, exp_err & PCHK);
      if (int'(count) > max_count) max_count = int'(count);
    end
  endtask

  // Words leaving the FIFO are recorded mid-cycle, once inputs have settled.
  task automatic rx_loop();
    forever begin
      @(negedge clk);
      #2;
      if (!rst && m_valid && m_ready) rx_q.push_back(m_data);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ack(input logic lvl, input string name);
    int n = 0;
    while (ack_out !== lvl && n < 200) begin
      tick();
      n++;
    end
    check(name, ack_out, lvl);
  endtask

  task automatic hs(input logic [DATA_W-1:0] d);
    req_in  = 1'b1;
    data_in = d;
    tick();
    wait_ack(1'b1, "hs_ack_rise");
    req_in  = 1'b0;
    data_in = 8'($urandom);
    wait_ack(1'b0, "hs_ack_fall");
  endtask

  task automatic drain_expect(input logic [DATA_W-1:0] w);
    check("drain_valid", m_valid, 1);
    check("drain_data", m_data, w);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_in = 1'b0; data_in = '0; m_ready = 1'b0;
    fork
      model_loop();
      rx_loop();
    join_none
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_ack", ack_out, 0);
    check("reset_count", 32'(count), 0);
    check("reset_valid", m_valid, 0);
    check("reset_proto", proto_err, 0);

    // Single transfer: ack rises exactly SYNC_STAGES+1 edges after req_in.
    req_in = 1'b1; data_in = 8'hA5;
    tick(); tick();
    check("single_ack_early", ack_out, 0);
    tick();
    check("single_ack_rise", ack_out, 1);
    check("single_valid", m_valid, 1);
    check("single_data", m_data, 8'hA5);
    check("single_count", 32'(count), 1);
    req_in = 1'b0;
    tick(); tick();
    check("single_ack_hold", ack_out, 1);
    tick();
    check("single_ack_fall", ack_out, 0);
    drain_expect(8'hA5);
    check("single_empty", 32'(count), 0);

    // Fill and backpressure.
    for (int i = 1; i <= 4; i++) hs(8'(i));
    check("fill_count", 32'(count), 4);
    req_in = 1'b1; data_in = 8'h05;
    repeat (8) tick();
    check("bp_ack", ack_out, 0);
    check("bp_count", 32'(count), 4);
    drain_expect(8'h01);
    wait_ack(1'b1, "bp_ack_late");
    check("bp_count_after", 32'(count), 4);
    req_in = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");
    for (int i = 2; i <= 5; i++) drain_expect(8'(i));
    check("bp_empty", 32'(count), 0);

    // Push and pop on the same edge.
    hs(8'h10); hs(8'h11);
    check("pp_count_pre", 32'(count), 2);
    check("pp_head_pre", m_data, 8'h10);
    req_in = 1'b1; data_in = 8'h12;
    tick(); tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("pp_ack", ack_out, 1);
    check("pp_count", 32'(count), 2);
    check("pp_head", m_data, 8'h11);
    req_in = 1'b0;
    wait_ack(1'b0, "pp_ack_fall");
    drain_expect(8'h11);
    drain_expect(8'h12);

    // Pointer wrap with continuous draining.
    max_count = 0;
    rx_q.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) hs(8'(i));
    repeat (4) tick();
    m_ready = 1'b0;
    check("wrap_rx_size", rx_q.size(), 10);
    for (int i = 0; i < rx_q.size() && i < 10; i++) check("wrap_order", rx_q[i], i);
    check("wrap_max_count_ok", max_count <= DEPTH, 1);

    // Randomized handshakes against random consumer readiness.
    rand_ready = 1'b1;
    repeat (40) begin
      hs(8'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_ready = 1'b0;
    m_ready = 1'b1;
    repeat (8) tick();
    m_ready = 1'b0;
    check("rand_empty", 32'(count), 0);

    // Reset while in ACK with three words buffered and req_in held high.
    hs(8'h21); hs(8'h22);
    req_in = 1'b1; data_in = 8'h23;
    tick();
    wait_ack(1'b1, "rst_ack_pre");
    check("rst_count_pre", 32'(count), 3);
    rst = 1'b1;
    tick();
    check("rst_ack", ack_out, 0);
    check("rst_count", 32'(count), 0);
    check("rst_valid", m_valid, 0);
    rst = 1'b0;
    tick(); tick();
    check("rst_repush_early", ack_out, 0);
    tick();
    check("rst_repush_ack", ack_out, 1);
    check("rst_repush_count", 32'(count), 1);
    check("rst_repush_data", m_data, 8'h23);
    req_in = 1'b0;
    wait_ack(1'b0, "rst_ack_fall");
    drain_expect(8'h23);

    // Request withdrawn while stalled on a full FIFO.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("proto_clear", proto_err, 0);
    for (int i = 0; i < 4; i++) hs(8'h31 + 8'(i));
    req_in = 1'b1; data_in = 8'h35;
    repeat (6) tick();
    check("proto_stall_ack", ack_out, 0);
    req_in = 1'b0;
    repeat (6) tick();
    check("proto_err_set", proto_err, PCHK);
    repeat (3) tick();
    check("proto_err_sticky", proto_err, PCHK);
    check("proto_count", 32'(count), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("proto_err_reset", proto_err, 0);
    check("proto_count_reset", 32'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
